pc_sequencer: RTL and testbench

//  Parametrised program-counter unit for the pipelined CPU fetch stage. Holds the

---
 rtl/pc_sequencer.sv | 118 +++++++++++
 tb/tb_pc_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Fetch-stage program counter. Each cycle it holds after reset,
//                takes an exception redirect, a branch target, a stall hold or
//                a sequential increment. Misaligned branch targets trap to
//                FAULT_VEC and raise a sticky fault flag. Stalled RUN cycles
//                are counted in a saturating counter.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_sequencer #(
    parameter int                 WIDTH     = 64,
    parameter int                 INC       = 4,
    parameter logic [WIDTH-1:0]   RESET_VEC = '0,
    parameter logic [WIDTH-1:0]   FAULT_VEC = 'h100,
    parameter int                 HOLD_CYC  = 2,
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [WIDTH-1:0]   br_target,
    input  logic               redirect,
    input  logic [WIDTH-1:0]   redirect_pc,
    input  logic               clr_fault,
    output logic [WIDTH-1:0]   pc,
    output logic [WIDTH-1:0]   pc_plus,
    output logic               fetch_valid,
    output logic               fault,
    output logic [CNT_W-1:0]   stall_cnt
);

    // Hold counter only has to reach HOLD_CYC-1; keep at least one bit.
    localparam int              HC_W        = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HC_W-1:0] c_hold_last = HC_W'(HOLD_CYC - 1);
    localparam logic [WIDTH-1:0] c_inc      = WIDTH'(INC);
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        S_HOLD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [HC_W-1:0]    r_hold_cnt;
    logic [WIDTH-1:0]   r_pc;
    logic               r_fetch_valid;
    logic               r_fault;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic [WIDTH-1:0]   w_pc_plus;
    logic               w_misaligned;
    logic               w_trap;

    // Sequential address and trap decode; a redirect suppresses any branch trap.
    always_comb begin
        w_pc_plus    = r_pc + c_inc;
        w_misaligned = (br_target[1:0] != 2'b00);
        w_trap       = !redirect && br_taken && w_misaligned;
    end

    // Hold/run sequencing, next-pc selection, sticky fault and stall counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_HOLD;
            r_hold_cnt    <= '0;
            r_pc          <= RESET_VEC;
            r_fetch_valid <= 1'b0;
            r_fault       <= 1'b0;
            r_stall_cnt   <= '0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    // pc sits at RESET_VEC; it becomes the first valid fetch.
                    if (r_hold_cnt == c_hold_last) begin
                        r_state       <= S_RUN;
                        r_fetch_valid <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HC_W'(1);
                    end
                end
                S_RUN: begin
                    // Flush beats hold: redirect, then branch, then stall.
                    if (redirect) begin
                        r_pc <= redirect_pc;
                    end else if (br_taken) begin
                        r_pc <= w_misaligned ? FAULT_VEC : br_target;
                    end else if (stall) begin
                        if (r_stall_cnt != c_cnt_max) begin
                            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_pc <= w_pc_plus;
                    end

                    // A new trap wins over a clear on the same edge.
                    if (w_trap) begin
                        r_fault <= 1'b1;
                    end else if (clr_fault) begin
                        r_fault <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_HOLD;
                end
            endcase
        end
    end

    assign pc          = r_pc;
    assign pc_plus     = w_pc_plus;
    assign fetch_valid = r_fetch_valid;
    assign fault       = r_fault;
    assign stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Directed self-checking bench for pc_sequencer. Two instances
//                share stimulus: one with the default 16-bit stall counter and
//                one with a 2-bit counter to observe saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [63:0] br_target;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        clr_fault;

    logic [63:0] pc_a, pc_plus_a, pc_b, pc_plus_b;
    logic        fv_a, fault_a, fv_b, fault_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    int n_vec;
    int n_err;

    pc_sequencer u_dut_a (
        .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
        .br_target(br_target), .redirect(redirect), .redirect_pc(redirect_pc),
        .clr_fault(clr_fault), .pc(pc_a), .pc_plus(pc_plus_a),
        .fetch_valid(fv_a), .fault(fault_a), .stall_cnt(cnt_a)
    );

    pc_sequencer #(.CNT_W(2)) u_dut_b (
        .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
        .br_target(br_target), .redirect(redirect), .redirect_pc(redirect_pc),
        .clr_fault(clr_fault), .pc(pc_b), .pc_plus(pc_plus_b),
        .fetch_valid(fv_b), .fault(fault_b), .stall_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_core(input string tag, input logic [63:0] epc,
                              input logic efv, input logic efault);
        check({tag, ".pc"},    pc_a,  epc);
        check({tag, ".fv"},    {63'd0, fv_a},    {63'd0, efv});
        check({tag, ".fault"}, {63'd0, fault_a}, {63'd0, efault});
        check({tag, ".pc_b"},  pc_b,  epc);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = '0;
        redirect = 1'b0; redirect_pc = '0; clr_fault = 1'b0;

        // 1: reset state appears asynchronously, before any clock edge
        #1 reset = 1'b1;
        #1;
        check_core("rst_async", 64'h0, 1'b0, 1'b0);
        check("rst_cnt", {48'd0, cnt_a}, 64'd0);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_core("hold1", 64'h0, 1'b0, 1'b0);
        tick();
        check_core("hold2", 64'h0, 1'b1, 1'b0);
        tick();
        check_core("run1", 64'h4, 1'b1, 1'b0);
        tick();
        check_core("run2", 64'h8, 1'b1, 1'b0);
        check("pc_plus", pc_plus_a, 64'hC);

        // 2: three stalls freeze pc and count
        stall = 1'b1;
        repeat (3) tick();
        check_core("stall3", 64'h8, 1'b1, 1'b0);
        check("stall3.cnt_a", {48'd0, cnt_a}, 64'd3);
        check("stall3.cnt_b", {62'd0, cnt_b}, 64'd3);
        stall = 1'b0;
        tick();
        check_core("unstall", 64'hC, 1'b1, 1'b0);

        // 3: branch overrides stall, counter untouched
        stall = 1'b1; br_taken = 1'b1; br_target = 64'h40;
        tick();
        check_core("br_stall", 64'h40, 1'b1, 1'b0);
        check("br_stall.cnt", {48'd0, cnt_a}, 64'd3);
        br_taken = 1'b0;
        repeat (2) tick();
        check_core("stall_more", 64'h40, 1'b1, 1'b0);
        check("sat.cnt_a", {48'd0, cnt_a}, 64'd5);
        check("sat.cnt_b", {62'd0, cnt_b}, 64'd3);
        stall = 1'b0;

        // 4: misaligned branch traps; clear; set beats clear
        br_taken = 1'b1; br_target = 64'h42;
        tick();
        check_core("trap", 64'h100, 1'b1, 1'b1);
        br_taken = 1'b0; clr_fault = 1'b1;
        tick();
        check_core("clr", 64'h104, 1'b1, 1'b0);
        br_taken = 1'b1;
        tick();
        check_core("set_wins", 64'h100, 1'b1, 1'b1);
        br_taken = 1'b0; clr_fault = 1'b0;
        tick();
        check_core("sticky", 64'h104, 1'b1, 1'b1);
        clr_fault = 1'b1;
        tick();
        check_core("clr2", 64'h108, 1'b1, 1'b0);
        clr_fault = 1'b0;

        // 5: redirect drops concurrent misaligned branch and beats stall
        redirect = 1'b1; redirect_pc = 64'h200;
        br_taken = 1'b1; br_target = 64'h42; stall = 1'b1;
        tick();
        check_core("redir", 64'h200, 1'b1, 1'b0);
        check("redir.cnt", {48'd0, cnt_a}, 64'd5);
        br_taken = 1'b0; stall = 1'b0;

        // 6: wrap at top of address space
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        check_core("top", 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0);
        check("top.plus", pc_plus_a, 64'h0);
        redirect = 1'b0;
        tick();
        check_core("wrap", 64'h0, 1'b1, 1'b0);
        redirect = 1'b1; redirect_pc = 64'h3;
        tick();
        check_core("redir_unaligned", 64'h3, 1'b1, 1'b0);
        redirect = 1'b0;
        tick();
        check_core("seq_unaligned", 64'h7, 1'b1, 1'b0);

        // reset mid-cycle takes effect without a clock edge
        #2 reset = 1'b1;
        #1;
        check_core("rst_mid", 64'h0, 1'b0, 1'b0);
        check("rst_mid.cnt_a", {48'd0, cnt_a}, 64'd0);
        check("rst_mid.cnt_b", {62'd0, cnt_b}, 64'd0);
        tick();
        reset = 1'b0; stall = 1'b1;
        tick();
        check_core("rehold1", 64'h0, 1'b0, 1'b0);
        tick();
        check_core("rehold2", 64'h0, 1'b1, 1'b0);
        check("rehold.cnt", {48'd0, cnt_a}, 64'd0);
        tick();
        check_core("rerun_stall", 64'h0, 1'b1, 1'b0);
        check("rerun.cnt", {48'd0, cnt_a}, 64'd1);
        stall = 1'b0;
        tick();
        check_core("rerun", 64'h4, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
